// File: rtl/puf_response_vote_conditioner_if.sv
// Request/raw-PUF/response bundle for the PUF majority-vote conditioner.
// Handshakes: a request transfers on a clock edge where req_valid && req_ready;
// a result is held while resp_valid is high and is consumed on the edge where
// resp_ack is seen; raw_response is only meaningful in a cycle with raw_ready high.
interface puf_response_vote_conditioner_if #(
  parameter int RESP_W = 16,
  parameter int CHAL_W = 5
);
  logic              req_valid;
  logic [CHAL_W-1:0] req_challenge;
  logic              req_ready;
  logic              puf_generate;
  logic [CHAL_W-1:0] puf_challenge;
  logic [RESP_W-1:0] raw_response;
  logic              raw_ready;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic [RESP_W-1:0] resp_unstable_mask;
  logic              resp_error;
  logic              resp_ack;

  modport slave (
    input  req_valid, req_challenge, raw_response, raw_ready, resp_ack,
    output req_ready, puf_generate, puf_challenge, resp_valid, resp_data,
           resp_unstable_mask, resp_error
  );

  modport master (
    output req_valid, req_challenge, raw_response, raw_ready, resp_ack,
    input  req_ready, puf_generate, puf_challenge, resp_valid, resp_data,
           resp_unstable_mask, resp_error
  );
endinterface

// File: rtl/puf_response_vote_conditioner.sv
// Triggers the raw PUF NUM_EVAL times per challenge and majority-votes each bit.
// Optional macro PUF_VOTE_STABILITY_CHECK_EN: builds the unstable-bit mask and flags too many unstable bits.
module puf_response_vote_conditioner #(
  parameter int RESP_W       = 16,
  parameter int CHAL_W       = 5,
  parameter int NUM_EVAL     = 5,
  parameter int TIMEOUT_CYC  = 255,
  parameter int MAX_UNSTABLE = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  puf_response_vote_conditioner_if.slave        bus,
  output logic [2:0]                            o_dbg_state
);
  localparam int CW = $clog2(NUM_EVAL + 1);
  localparam int EW = $clog2(NUM_EVAL);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HALF      = CW'(NUM_EVAL / 2);
  localparam logic [EW-1:0] EVAL_LAST = EW'(NUM_EVAL - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

  if (NUM_EVAL < 3 || (NUM_EVAL % 2) == 0 || TIMEOUT_CYC < 1 || MAX_UNSTABLE < 0) begin : g_bad_params
    $error("puf_response_vote_conditioner: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_VOTE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [CHAL_W-1:0]           r_chal;
  logic [RESP_W-1:0][CW-1:0]   r_ones;
  logic [EW-1:0]               r_eval;
  logic [WW-1:0]               r_wait;
  logic [RESP_W-1:0]           r_data;
  logic                        r_err;
  logic [RESP_W-1:0]           w_vote_data;
  logic                        w_vote_err;

  always_comb begin
    w_vote_data = '0;
    for (int i = 0; i < RESP_W; i++) begin
      w_vote_data[i] = (r_ones[i] > HALF);
    end
  end

`ifdef PUF_VOTE_STABILITY_CHECK_EN
  localparam int PW = $clog2(RESP_W + 1);
  logic [RESP_W-1:0] r_mask;
  logic [RESP_W-1:0] w_vote_mask;
  logic [PW-1:0]     w_pop;

  always_comb begin
    w_vote_mask = '0;
    w_pop       = '0;
    for (int i = 0; i < RESP_W; i++) begin
      w_vote_mask[i] = (r_ones[i] != '0) && (r_ones[i] != CW'(NUM_EVAL));
      w_pop          = w_pop + PW'(w_vote_mask[i]);
    end
  end

  assign w_vote_err = (int'(w_pop) > MAX_UNSTABLE);
  assign bus.resp_unstable_mask = r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == S_VOTE) begin
      r_mask <= w_vote_mask;
    end else if (r_state == S_WAIT && !bus.raw_ready && r_wait == WAIT_LAST) begin
      r_mask <= '0;
    end
  end
`else
  assign w_vote_err = 1'b0;
  assign bus.resp_unstable_mask = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.req_ready    = 1'b0;
    bus.puf_generate = 1'b0;
    bus.resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.puf_generate = 1'b1;
        w_next           = S_WAIT;
      end
      // A raw sample landing on the last allowed wait cycle is still taken.
      S_WAIT: begin
        if (bus.raw_ready)            w_next = S_ACCUM;
        else if (r_wait == WAIT_LAST) w_next = S_DONE;
      end
      S_ACCUM: w_next = (r_eval == EVAL_LAST) ? S_VOTE : S_ISSUE;
      S_VOTE:  w_next = S_DONE;
      S_DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chal <= '0;
      r_ones <= '0;
      r_eval <= '0;
      r_wait <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_chal <= bus.req_challenge;
            r_ones <= '0;
            r_eval <= '0;
          end
        end
        S_ISSUE: r_wait <= '0;
        S_WAIT: begin
          if (bus.raw_ready) begin
            for (int i = 0; i < RESP_W; i++) begin
              r_ones[i] <= r_ones[i] + CW'(bus.raw_response[i]);
            end
          end else if (r_wait == WAIT_LAST) begin
            r_err  <= 1'b1;
            r_data <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_ACCUM: begin
          if (r_eval != EVAL_LAST) r_eval <= r_eval + 1'b1;
        end
        S_VOTE: begin
          r_data <= w_vote_data;
          r_err  <= w_vote_err;
        end
        default: ;
      endcase
    end
  end

  assign bus.puf_challenge = r_chal;
  assign bus.resp_data     = r_data;
  assign bus.resp_error    = r_err;
  assign o_dbg_state       = r_state;
endmodule

// File: doc/puf_response_vote_conditioner.md
Name: puf_response_vote_conditioner

Overview:
- Sits between the raw PUF core and the PUF/counter integration logic that consumes `puf_response` / `puf_ready`.
- For each challenge, triggers the raw PUF NUM_EVAL times and majority-votes every response bit.
- Delivers one stabilised response plus a per-bit instability mask over a valid/ack handshake.
- A timeout guards against a dead PUF core.

Parameters:
- RESP_W, 16: response width in bits.
- CHAL_W, 5: challenge width in bits.
- NUM_EVAL, 5: raw evaluations per request; must be odd and ≥3.
- TIMEOUT_CYC, 255: maximum cycles spent waiting for raw_ready per evaluation.
- MAX_UNSTABLE, 2: maximum permitted non-unanimous bits; used only with the optional feature.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request for a conditioned response.
- req_challenge  in  CHAL_W  challenge; captured on accept.
- req_ready  out  1  high only in IDLE.
- puf_generate  out  1  one-cycle trigger pulse to the raw PUF.
- puf_challenge  out  CHAL_W  captured challenge; held stable for the whole request.
- raw_response  in  RESP_W  raw PUF output; valid when raw_ready is high.
- raw_ready  in  1  one-cycle pulse marking raw_response valid.
- resp_valid  out  1  conditioned result available.
- resp_data  out  RESP_W  majority-voted response.
- resp_unstable_mask  out  RESP_W  1 = bit was not unanimous across evaluations.
- resp_error  out  1  timeout, or stability violation when the optional feature is compiled in.
- resp_ack  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all counters cleared.
  - req_ready=1; puf_generate=0; puf_challenge=0.
  - resp_valid=0; resp_data=0; resp_unstable_mask=0; resp_error=0.
- Per-bit ones-counters: RESP_W counters, each $clog2(NUM_EVAL+1) bits wide. Evaluation counter eval_cnt: 0..NUM_EVAL-1. Wait counter: 0..TIMEOUT_CYC.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture challenge, clear the ones-counters and eval_cnt, go to ISSUE.
- ISSUE:
  - puf_generate=1 for exactly this cycle.
  - Clear the wait counter, go to WAIT.
- WAIT:
  - On raw_ready: add raw_response[i] to ones[i] for every bit; go to ACCUM.
  - Else if wait counter == TIMEOUT_CYC-1: set resp_error=1 and resp_data=0, go to DONE.
  - Else increment the wait counter.
  - If raw_ready and timeout expiry coincide, raw_ready wins.
- ACCUM:
  - If eval_cnt == NUM_EVAL-1, go to VOTE.
  - Else increment eval_cnt and go to ISSUE.
- VOTE:
  - resp_data[i] = (ones[i] > NUM_EVAL/2).
  - resp_unstable_mask[i] = (ones[i] != 0) && (ones[i] != NUM_EVAL).
  - resp_error=0. Go to DONE.
- DONE:
  - resp_valid=1; outputs are held stable.
  - On resp_ack: resp_valid=0, go to IDLE next cycle.
  - resp_ack outside DONE is ignored.
- raw_ready outside WAIT is ignored; counters are unchanged.
- req_valid outside IDLE is ignored; no queuing.
- Latency with zero-delay raw_ready (raw_ready in the cycle after puf_generate): accept → resp_valid = 3*NUM_EVAL+2 cycles.
  - NUM_EVAL=5 gives 17 cycles.
- A new request may be accepted the cycle after returning to IDLE.
- Reset asserted mid-operation aborts immediately to the reset values; a raw_ready arriving later is ignored.

Optional Feature:
- Macro: PUF_VOTE_STABILITY_CHECK_EN.
- Defined:
  - In VOTE, if popcount(resp_unstable_mask) > MAX_UNSTABLE, then resp_error=1.
  - resp_data and resp_unstable_mask still carry the voted values.
- Undefined:
  - resp_unstable_mask is tied to 0.
  - No popcount logic is built.
  - resp_error is set only by timeout.

Test Plan:
- Stable PUF: NUM_EVAL=5, raw_response=0xA5A5 on all 5 evaluations → resp_valid with resp_data=0xA5A5, mask=0x0000, error=0. Five puf_generate pulses seen; latency 17 cycles with immediate raw_ready.
- Noisy PUF: evaluations 0x00FF, 0xFF00, 0x00FF, 0xFF00, 0x00FF → resp_data=0x00FF, mask=0xFFFF (macro defined). resp_error=1 with the macro defined (16 > 2); resp_error=0 with it undefined.
- Timeout: accept a request, never pulse raw_ready → resp_valid after TIMEOUT_CYC cycles in WAIT with resp_error=1 and resp_data=0. Then ack; req_ready=1 next cycle.
- Back-pressure: hold resp_ack=0 for 10 cycles after resp_valid → resp_valid and resp_data remain constant. req_ready=0 and a req_valid pulse is ignored. Ack → IDLE.
- Reset mid-operation: assert rst during the 3rd WAIT, then release. A late raw_ready is ignored; all outputs are at reset values. A fresh request with 0x1234 ×5 → resp_data=0x1234.
- Coincident events: raw_ready in the cycle the timeout would expire → sample accepted, no error. Spurious raw_ready in IDLE → no effect on the next result.
